// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and counter sizing helper.
// The PARITY state is reachable only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Width of a counter that must hold 0..clks_per_bit-1.
  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an idle-high asynchronous serial line.
// Both flops reset to 1 so that reset never looks like a start bit.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output, framing/overrun detection.
// Define UART_RX_PARITY_EN to expect and check one parity bit after the data bits.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 279,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  logic din_s;

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_fail;

  logic                   load;
  logic                   rx_valid_d;
  logic                   frame_d, overrun_d, parity_d;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_s)
  );

`ifdef UART_RX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  logic par_bad_q, par_bad_d;

  assign parity_fail = par_bad_q;
`else
  logic unused_parity_cfg;

  assign unused_parity_cfg = (PARITY_ODD != 0);
  assign parity_fail       = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path through
    // the case statement can hold a value and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    frame_d    = 1'b0;
    overrun_d  = 1'b0;
    parity_d   = 1'b0;
    load       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!din_s) state_d = START;
      end

      // Re-check the line at mid start bit; a short low pulse is a glitch.
      START: begin
        if (cnt_q == HALF) begin
          if (din_s) begin
            state_d = IDLE;
          end else begin
            cnt_d      = '0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            state_d    = DATA;
`ifdef UART_RX_PARITY_EN
            par_bad_d  = 1'b0;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = din_s;
          bit_idx_d        = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          par_bad_d = (din_s != ((^shift_q) ^ ODD_BIT));
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      // Leaving at the last stop sample (not its end) gives half a bit of slack
      // for the next start edge.
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (!din_s) begin
            frame_d = 1'b1;
            state_d = IDLE;
          end else if (stop_idx_q == LAST_STOP) begin
            state_d = IDLE;
            if (parity_fail)                 parity_d  = 1'b1;
            else if (!rx_valid || rx_ready)  load      = 1'b1;
            else                             overrun_d = 1'b1;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_valid_d = rx_valid;
    if (load)                       rx_valid_d = 1'b1;
    else if (rx_valid && rx_ready)  rx_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      rx_valid    <= rx_valid_d;
      frame_err   <= frame_d;
      overrun_err <= overrun_d;
      parity_err  <= parity_d;
      if (load) rx_data <= shift_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) par_bad_q <= 1'b0;
    else     par_bad_q <= par_bad_d;
  end
`endif

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed self-checking bench for uart_rx_param at 16 clks/bit, 8 data bits, 1 stop.
// Parity scenarios run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_param;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int SB   = 1;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Edges from start-bit drive to rx_valid: 2 sync + 1 IDLE->START + HALF+1 in
  // START, then one bit period per data/parity/stop bit (156 for 8N1).
  localparam int LAT = 3 + CPB / 2 + 1 + CPB * (DB + PB + SB);

  logic          clk = 1'b0;
  logic          rst;
  logic          din;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_err;
  logic          overrun_err;
  logic          parity_err;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  uart_rx_param #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .STOP_BITS    (SB),
    .PARITY_ODD   (PODD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts rising edges and high cycles of every output pulse.
  logic          prev_valid = 1'b0, prev_fe = 1'b0, prev_oe = 1'b0, prev_pe = 1'b0;
  int            valid_rises = 0, last_rise_cyc = 0, last_fe_cyc = 0;
  int            fe_rise = 0, fe_hi = 0, oe_rise = 0, oe_hi = 0, pe_rise = 0, pe_hi = 0;
  logic [DB-1:0] rise_data[$];

  always @(negedge clk) begin
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      valid_rises++;
      last_rise_cyc = cyc;
      rise_data.push_back(rx_data);
    end
    if (frame_err === 1'b1) begin
      fe_hi++;
      if (prev_fe !== 1'b1) begin fe_rise++; last_fe_cyc = cyc; end
    end
    if (overrun_err === 1'b1) begin
      oe_hi++;
      if (prev_oe !== 1'b1) oe_rise++;
    end
    if (parity_err === 1'b1) begin
      pe_hi++;
      if (prev_pe !== 1'b1) pe_rise++;
    end
    prev_valid = rx_valid;
    prev_fe    = frame_err;
    prev_oe    = overrun_err;
    prev_pe    = parity_err;
  end

  task automatic send_bit(input logic b);
    din = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic stop_val,
                            input logic par_flip, output int c0);
    logic pbit;
    pbit = (^data) ^ (PODD != 0) ^ par_flip;
    @(posedge clk);
    #1;
    c0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(data[i]);
    for (int i = 0; i < PB; i++) send_bit(pbit);
    for (int i = 0; i < SB; i++) send_bit(stop_val);
    din = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 1'b1; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", rx_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
      fails++; $display("FAIL reset_errs: got %b want 000", {frame_err, overrun_err, parity_err});
    end
  endtask

  task automatic test_basic();
    int c0, vr0, er0;
    vr0 = valid_rises; er0 = fe_rise + oe_rise + pe_rise;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, c0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++; if (valid_rises - vr0 != 1) begin fails++; $display("FAIL basic_count: got %0d want 1", valid_rises - vr0); end
    tests++; if (rise_data[$] !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h want a5", rise_data[$]); end
    tests++; if (last_rise_cyc != c0 + LAT) begin
      fails++; $display("FAIL basic_latency: got %0d want %0d", last_rise_cyc - c0, LAT);
    end
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL basic_accept: got %b want 0", rx_valid); end
    tests++; if (fe_rise + oe_rise + pe_rise != er0) begin fails++; $display("FAIL basic_errs: got %0d want 0", fe_rise + oe_rise + pe_rise - er0); end
  endtask

  task automatic test_glitch();
    int vr0, er0;
    vr0 = valid_rises; er0 = fe_rise + oe_rise + pe_rise;
    @(posedge clk);
    #1 din = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy: got %b want 1", busy); end
    din = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_idle: got %b want 0", busy); end
    tests++; if (valid_rises != vr0) begin fails++; $display("FAIL glitch_valid: got %0d want 0", valid_rises - vr0); end
    tests++; if (fe_rise + oe_rise + pe_rise != er0) begin fails++; $display("FAIL glitch_errs: got %0d want 0", fe_rise + oe_rise + pe_rise - er0); end
  endtask

  task automatic test_frame_err();
    int c0, vr0, fr0, fh0, oe0, pe0;
    vr0 = valid_rises; fr0 = fe_rise; fh0 = fe_hi; oe0 = oe_rise; pe0 = pe_rise;
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0, c0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    tests++; if (fe_rise - fr0 != 1 || fe_hi - fh0 != 1) begin
      fails++; $display("FAIL frame_pulse: got rises=%0d high=%0d want 1/1", fe_rise - fr0, fe_hi - fh0);
    end
    tests++; if (last_fe_cyc != c0 + LAT) begin fails++; $display("FAIL frame_time: got %0d want %0d", last_fe_cyc - c0, LAT); end
    tests++; if (valid_rises != vr0 || rx_valid !== 1'b0) begin
      fails++; $display("FAIL frame_valid: got rises=%0d valid=%b want 0/0", valid_rises - vr0, rx_valid);
    end
    tests++; if (oe_rise != oe0 || pe_rise != pe0) begin fails++; $display("FAIL frame_excl: got oe=%0d pe=%0d want 0/0", oe_rise - oe0, pe_rise - pe0); end
  endtask

  task automatic test_overrun();
    int c0, vr0, or0, oh0, fr0;
    vr0 = valid_rises; or0 = oe_rise; oh0 = oe_hi; fr0 = fe_rise;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, c0);
    send_frame(8'h22, 1'b1, 1'b0, c0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++; if (valid_rises - vr0 != 1) begin fails++; $display("FAIL ovr_count: got %0d want 1", valid_rises - vr0); end
    tests++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
      fails++; $display("FAIL ovr_hold: got %h/%b want 11/1", rx_data, rx_valid);
    end
    tests++; if (oe_rise - or0 != 1 || oe_hi - oh0 != 1) begin
      fails++; $display("FAIL ovr_pulse: got rises=%0d high=%0d want 1/1", oe_rise - or0, oe_hi - oh0);
    end
    tests++; if (fe_rise != fr0) begin fails++; $display("FAIL ovr_frame: got %0d want 0", fe_rise - fr0); end
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL ovr_accept: got %b want 0", rx_valid); end
    rx_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    int c0, c1, vr0, er0;
    vr0 = valid_rises; er0 = fe_rise + oe_rise + pe_rise;
    rx_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0, c0);
    send_frame(8'hC3, 1'b1, 1'b0, c1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++; if (valid_rises - vr0 != 2) begin fails++; $display("FAIL b2b_count: got %0d want 2", valid_rises - vr0); end
    else begin
      tests++; if (rise_data[$-1] !== 8'h5A || rise_data[$] !== 8'hC3) begin
        fails++; $display("FAIL b2b_data: got %h %h want 5a c3", rise_data[$-1], rise_data[$]);
      end
    end
    tests++; if (last_rise_cyc != c1 + LAT) begin fails++; $display("FAIL b2b_latency: got %0d want %0d", last_rise_cyc - c1, LAT); end
    tests++; if (fe_rise + oe_rise + pe_rise != er0) begin fails++; $display("FAIL b2b_errs: got %0d want 0", fe_rise + oe_rise + pe_rise - er0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int c0, vr0, pr0, ph0, fr0, oe0;
    vr0 = valid_rises; pr0 = pe_rise; ph0 = pe_hi; fr0 = fe_rise; oe0 = oe_rise;
    rx_ready = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1, c0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++; if (pe_rise - pr0 != 1 || pe_hi - ph0 != 1) begin
      fails++; $display("FAIL par_pulse: got rises=%0d high=%0d want 1/1", pe_rise - pr0, pe_hi - ph0);
    end
    tests++; if (valid_rises != vr0) begin fails++; $display("FAIL par_drop: got %0d want 0", valid_rises - vr0); end
    tests++; if (fe_rise != fr0 || oe_rise != oe0) begin fails++; $display("FAIL par_excl: got fe=%0d oe=%0d want 0/0", fe_rise - fr0, oe_rise - oe0); end
    send_frame(8'h07, 1'b1, 1'b0, c0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++; if (valid_rises - vr0 != 1 || rise_data[$] !== 8'h07) begin
      fails++; $display("FAIL par_good: got rises=%0d data=%h want 1/07", valid_rises - vr0, rise_data[$]);
    end
    tests++; if (pe_rise - pr0 != 1) begin fails++; $display("FAIL par_good_err: got %0d want 1", pe_rise - pr0); end
  endtask
`else
  task automatic test_parity();
    tests++; if (pe_hi != 0) begin fails++; $display("FAIL par_off: got %0d high cycles want 0", pe_hi); end
  endtask
`endif

  task automatic test_reset_mid();
    int c0, vr0, er0;
    vr0 = valid_rises; er0 = fe_rise + oe_rise + pe_rise;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy: got %b want 1", busy); end
    rst = 1'b1; din = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_state: got busy=%b valid=%b want 0/0", busy, rx_valid);
    end
    send_frame(8'h99, 1'b1, 1'b0, c0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++; if (valid_rises - vr0 != 1 || rise_data[$] !== 8'h99) begin
      fails++; $display("FAIL rstmid_data: got rises=%0d data=%h want 1/99", valid_rises - vr0, rise_data[$]);
    end
    tests++; if (fe_rise + oe_rise + pe_rise != er0) begin fails++; $display("FAIL rstmid_errs: got %0d want 0", fe_rise + oe_rise + pe_rise - er0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_parity();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
